// File: rtl/acq_sequencer.sv
// Run controller for the acquisition engines: arms one selected engine, counts ADC samples,
// parks it after the programmed count or an abort, and muxes its pins. Optional watchdog: ACQ_SEQ_TIMEOUT_EN.
module acq_sequencer #(
    parameter int          N_MODES      = 4,
    parameter int          COUNT_W      = 24,
    parameter int          PARK_CLKS    = 4,
    parameter logic [3:0]  IDLE_AZMUX   = 4'b0000,
    parameter logic        IDLE_PC      = 1'b0,
    parameter logic [23:0] TIMEOUT_CLKS = 24'hFFFFFF
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [1:0]             i_cfg_mode,
    input  logic [COUNT_W-1:0]     i_cfg_nsamples,
    input  logic                   i_cfg_start,
    input  logic                   i_cfg_abort,
    input  logic                   i_adc_measure_valid,
    input  logic [N_MODES-1:0]     i_eng_trig,
    input  logic [N_MODES-1:0]     i_eng_pc,
    input  logic [4*N_MODES-1:0]   i_eng_azmux,
    input  logic [3*N_MODES-1:0]   i_eng_status,
    output logic [N_MODES-1:0]     o_arm_trigger,
    output logic                   o_adc_measure_trig,
    output logic                   o_sw_pc_ctl,
    output logic [3:0]             o_azmux,
    output logic [2:0]             o_status_out,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [COUNT_W-1:0]     o_sample_count,
    output logic                   o_err_timeout
);

    localparam int PARK_W = (PARK_CLKS > 1) ? $clog2(PARK_CLKS) : 1;
    localparam logic [PARK_W-1:0] PARK_LAST = PARK_W'(PARK_CLKS - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_PARK = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]          r_state;
    logic                r_arm_cnt;
    logic [PARK_W-1:0]   r_park_cnt;
    logic [1:0]          r_mode;
    logic [COUNT_W-1:0]  r_nsamples;
    logic [COUNT_W-1:0]  r_count;
    logic                r_valid_d;
    logic [N_MODES-1:0]  r_arm;
    logic                r_trig;
    logic                r_pc;
    logic [3:0]          r_azmux;
    logic [2:0]          r_status;
    logic                r_busy;
    logic                r_done;

    logic [2:0]          w_next;
    logic                w_edge;
    logic                w_start_ok;
    logic                w_wd_expire;
    logic [COUNT_W-1:0]  w_count_plus;
    logic                w_count_hit;
    logic                w_sel_trig;
    logic                w_sel_pc;
    logic [3:0]          w_sel_azmux;
    logic [2:0]          w_sel_status;

    function automatic logic [N_MODES-1:0] f_onehot(input logic [1:0] m);
        logic [N_MODES-1:0] v;
        v = {N_MODES{1'b0}};
        for (int k = 0; k < N_MODES; k++) begin
            v[k] = (m == 2'(k));
        end
        return v;
    endfunction

    assign w_edge       = i_adc_measure_valid & ~r_valid_d;
    assign w_count_plus = r_count + {{(COUNT_W-1){1'b0}}, 1'b1};
    assign w_count_hit  = (r_nsamples != {COUNT_W{1'b0}}) && (w_count_plus == r_nsamples);
    assign w_start_ok   = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_cfg_start && !i_cfg_abort;

    // AND-OR mux of the selected engine's pins
    always_comb begin
        w_sel_trig   = 1'b0;
        w_sel_pc     = 1'b0;
        w_sel_azmux  = 4'b0000;
        w_sel_status = 3'b000;
        for (int k = 0; k < N_MODES; k++) begin
            w_sel_trig   = w_sel_trig   | (i_eng_trig[k] & (r_mode == 2'(k)));
            w_sel_pc     = w_sel_pc     | (i_eng_pc[k]   & (r_mode == 2'(k)));
            w_sel_azmux  = w_sel_azmux  | (i_eng_azmux[4*k +: 4]  & {4{r_mode == 2'(k)}});
            w_sel_status = w_sel_status | (i_eng_status[3*k +: 3] & {3{r_mode == 2'(k)}});
        end
    end

    // Next-state decode; abort outranks start and sample completion
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) w_next = S_ARM;
                else            w_next = S_IDLE;
            end
            S_ARM: begin
                if (i_cfg_abort)    w_next = S_PARK;
                else if (r_arm_cnt) w_next = S_RUN;
                else                w_next = S_ARM;
            end
            S_RUN: begin
                if (i_cfg_abort || (w_edge && w_count_hit) || w_wd_expire) w_next = S_PARK;
                else                                                       w_next = S_RUN;
            end
            S_PARK: begin
                if (r_park_cnt == PARK_LAST) w_next = S_DONE;
                else                         w_next = S_PARK;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State, counters and registered outputs, all driven from the next state
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_arm_cnt  <= 1'b0;
            r_park_cnt <= {PARK_W{1'b0}};
            r_mode     <= 2'd0;
            r_nsamples <= {COUNT_W{1'b0}};
            r_count    <= {COUNT_W{1'b0}};
            r_valid_d  <= 1'b0;
            r_arm      <= {N_MODES{1'b0}};
            r_trig     <= 1'b0;
            r_pc       <= IDLE_PC;
            r_azmux    <= IDLE_AZMUX;
            r_status   <= 3'b000;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_valid_d  <= i_adc_measure_valid;
            r_arm_cnt  <= (r_state == S_ARM) ? ~r_arm_cnt : 1'b0;
            r_park_cnt <= (r_state == S_PARK) ? r_park_cnt + {{(PARK_W-1){1'b0}}, 1'b1} : {PARK_W{1'b0}};
            if (w_start_ok) begin
                r_mode     <= i_cfg_mode;
                r_nsamples <= i_cfg_nsamples;
                r_count    <= {COUNT_W{1'b0}};
            end else if ((r_state == S_RUN) && w_edge) begin
                r_count    <= w_count_plus;
            end else begin
                r_count    <= r_count;
            end
            r_busy <= (w_next == S_ARM) || (w_next == S_RUN) || (w_next == S_PARK);
            r_done <= (w_next == S_DONE) && (r_state != S_DONE);
            r_arm  <= (w_next == S_RUN) ? f_onehot(r_mode) : {N_MODES{1'b0}};
            r_trig <= (w_next == S_RUN) ? w_sel_trig : 1'b0;
            if ((w_next == S_RUN) || (w_next == S_PARK)) begin
                r_pc     <= w_sel_pc;
                r_azmux  <= w_sel_azmux;
                r_status <= w_sel_status;
            end else begin
                r_pc     <= IDLE_PC;
                r_azmux  <= IDLE_AZMUX;
                r_status <= 3'b000;
            end
        end
    end

`ifdef ACQ_SEQ_TIMEOUT_EN
    logic [23:0] r_wd;
    logic        r_err;

    assign w_wd_expire   = (r_state == S_RUN) && !w_edge && (r_wd == (TIMEOUT_CLKS - 24'd1));
    assign o_err_timeout = r_err;

    // Watchdog restarts on RUN entry and on every counted sample
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wd  <= 24'd0;
            r_err <= 1'b0;
        end else begin
            if ((r_state != S_RUN) || w_edge) r_wd <= 24'd0;
            else                              r_wd <= r_wd + 24'd1;
            if (w_start_ok)       r_err <= 1'b0;
            else if (w_wd_expire) r_err <= 1'b1;
            else                  r_err <= r_err;
        end
    end
`else
    assign w_wd_expire   = 1'b0;
    assign o_err_timeout = (TIMEOUT_CLKS == 24'd0) & 1'b0;
`endif

    assign o_arm_trigger      = r_arm;
    assign o_adc_measure_trig = r_trig;
    assign o_sw_pc_ctl        = r_pc;
    assign o_azmux            = r_azmux;
    assign o_status_out       = r_status;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_sample_count     = r_count;

endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboard bench for acq_sequencer: stub engines with per-mode constant pins, random valid
// pulses and runs; a monitor checks pins every cycle and sample counts on each done pulse.
module tb_acq_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  cfg_mode;
    logic [23:0] cfg_nsamples;
    logic        cfg_start, cfg_abort, valid;
    logic [3:0]  eng_trig;
    logic [3:0]  eng_pc     = 4'b1010;
    logic [15:0] eng_azmux  = {4'h4, 4'h3, 4'h2, 4'h1};
    logic [11:0] eng_status = {3'd7, 3'd6, 3'd5, 3'd4};
    logic [3:0]  o_arm;
    logic        o_trig, o_pc, o_busy, o_done, o_err;
    logic [3:0]  o_azmux;
    logic [2:0]  o_status;
    logic [23:0] o_count;

    always #5 clk = ~clk;

    acq_sequencer #(.TIMEOUT_CLKS(24'd100)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_cfg_mode(cfg_mode), .i_cfg_nsamples(cfg_nsamples),
        .i_cfg_start(cfg_start), .i_cfg_abort(cfg_abort), .i_adc_measure_valid(valid),
        .i_eng_trig(eng_trig), .i_eng_pc(eng_pc), .i_eng_azmux(eng_azmux), .i_eng_status(eng_status),
        .o_arm_trigger(o_arm), .o_adc_measure_trig(o_trig), .o_sw_pc_ctl(o_pc), .o_azmux(o_azmux),
        .o_status_out(o_status), .o_busy(o_busy), .o_done(o_done), .o_sample_count(o_count),
        .o_err_timeout(o_err)
    );

    typedef struct { int count; bit armed; } exp_t;
    exp_t q_exp[$];
    int   errors = 0, checks = 0;
    int   m_mode = 0;
    bit   m_err = 1'b0, mon_en = 1'b0, armed_seen = 1'b0;
    logic [3:0] prev_trig = 4'd0, prev_arm = 4'd0;
    logic prev_busy = 1'b0, prev_done = 1'b0;
    int   busy_age = 0, park_age = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_exp(input int c, input bit a);
        exp_t e;
        e.count = c; e.armed = a;
        q_exp.push_back(e);
    endtask

    task automatic do_start(input int mode, input int ns);
        cfg_mode = 2'(mode); cfg_nsamples = 24'(ns); cfg_start = 1'b1;
        m_mode = mode;
        tick();
        m_err = 1'b0;
        cfg_start = 1'b0;
        cfg_mode = 2'($urandom); cfg_nsamples = 24'($urandom);
    endtask

    task automatic wait_arm();
        for (int n = 0; n < 20 && o_arm == 4'd0; n++) tick();
        chk("arm_seen", {63'd0, o_arm != 4'd0}, 64'd1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 400 && o_busy !== 1'b0; n++) tick();
        chk("idle_reached", {63'd0, o_busy}, 64'd0);
        tick();
    endtask

    task automatic pulse(input int low);
        valid = 1'b1; tick(); tick();
        valid = 1'b0;
        repeat (low) tick();
    endtask

    task automatic abort_pulse();
        cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
    endtask

    // Engine trig lines toggle freely on every engine
    initial begin
        eng_trig = 4'd0;
        forever begin @(posedge clk); #1; eng_trig = 4'($urandom); end
    end

    // Monitor: per-cycle pin checks and scoreboard pop on done
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_busy === 1'b0) begin
                chk("idle_arm", o_arm, 0);
                chk("idle_azmux", o_azmux, 0);
                chk("idle_pc", o_pc, 0);
                chk("idle_status", o_status, 0);
                chk("err_timeout", o_err, m_err);
            end
            if (o_arm !== 4'd0) begin
                chk("run_arm", o_arm, 64'd1 << m_mode);
                chk("run_azmux", o_azmux, m_mode + 1);
                chk("run_pc", o_pc, m_mode % 2);
                chk("run_status", o_status, m_mode + 4);
                chk("run_trig", o_trig, prev_trig[m_mode]);
            end else begin
                chk("trig_quiet", o_trig, 0);
            end
            if (o_busy && !prev_busy) begin busy_age = 0; armed_seen = 1'b0; end
            else if (o_busy) busy_age++;
            if (o_arm != 4'd0 && prev_arm == 4'd0) begin
                chk("arm_latency", busy_age, 2);
                armed_seen = 1'b1;
            end
            if (o_arm == 4'd0 && prev_arm != 4'd0) park_age = 0;
            else park_age++;
            if (o_done) begin
                if (prev_done) chk("done_width", 2, 1);
                if (q_exp.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q_exp.pop_front();
                    chk("done_count", o_count, e.count);
                    chk("done_armed", armed_seen, e.armed);
                    chk("done_busy", o_busy, 0);
                    if (e.armed) chk("park_clks", park_age, 4);
                end
            end
        end
        prev_trig = eng_trig; prev_arm = o_arm; prev_busy = o_busy; prev_done = o_done;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int mode, kind, ns, n;
        reset_n = 1'b0; cfg_mode = 2'd0; cfg_nsamples = 24'd0;
        cfg_start = 1'b0; cfg_abort = 1'b0; valid = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_busy", o_busy, 0);
        chk("rst_count", o_count, 0);
        chk("rst_done", o_done, 0);
        chk("rst_trig", o_trig, 0);
        mon_en = 1'b1;

        // 6 samples, slow engine, mode 0
        push_exp(6, 1'b1);
        do_start(0, 6);
        wait_arm();
        chk("t1_arm", o_arm, 4'b0001);
        for (int i = 0; i < 8; i++) pulse(48);
        wait_idle();
        chk("t1_hold_count", o_count, 6);

        // free-run, 1000 edges, last edge together with abort
        push_exp(1000, 1'b1);
        do_start(2, 0);
        wait_arm();
        chk("t2_arm", o_arm, 4'b0100);
        for (int i = 0; i < 999; i++) pulse($urandom_range(1, 3));
        valid = 1'b1; cfg_abort = 1'b1; tick();
        cfg_abort = 1'b0; tick(); valid = 1'b0;
        wait_idle();

        // start and abort together from idle are both dropped
        cfg_start = 1'b1; cfg_abort = 1'b1; tick();
        cfg_start = 1'b0; cfg_abort = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_no_busy", o_busy, 0);
            chk("t3_no_arm", o_arm, 0);
            tick();
        end

        // restart while running with a new mode is ignored
        push_exp(3, 1'b1);
        do_start(1, 0);
        wait_arm();
        tick(); tick();
        cfg_mode = 2'd3; cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        for (int i = 0; i < 3; i++) pulse(2);
        chk("t3_arm_kept", o_arm, 4'b0010);
        abort_pulse();
        wait_idle();

        // reset in the middle of a run
        do_start(3, 0);
        wait_arm();
        for (int i = 0; i < 3; i++) pulse(3);
        chk("t4_count", o_count, 3);
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        chk("t4_arm", o_arm, 0);
        chk("t4_azmux", o_azmux, 0);
        chk("t4_pc", o_pc, 0);
        chk("t4_count_clr", o_count, 0);
        chk("t4_busy", o_busy, 0);
        tick();

        // random runs: counted, free-run+abort, abort during ARM
        for (int r = 0; r < 12; r++) begin
            mode = $urandom_range(0, 3);
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                ns = $urandom_range(1, 8);
                push_exp(ns, 1'b1);
                do_start(mode, ns);
                wait_arm();
                for (int i = 0; i < ns + 2; i++) pulse($urandom_range(2, 5));
            end else if (kind == 1) begin
                n = $urandom_range(0, 10);
                push_exp(n, 1'b1);
                do_start(mode, 0);
                wait_arm();
                for (int i = 0; i < n; i++) pulse($urandom_range(1, 4));
                abort_pulse();
            end else begin
                push_exp(0, 1'b0);
                do_start(mode, $urandom_range(1, 5));
                abort_pulse();
                pulse(2);
            end
            wait_idle();
        end

`ifdef ACQ_SEQ_TIMEOUT_EN
        // watchdog: no samples for 100 clocks in RUN
        push_exp(0, 1'b1);
        do_start(0, 0);
        wait_arm();
        n = 0;
        while (o_arm != 4'd0 && n < 300) begin n++; tick(); end
        chk("t6_run_clks", n, 100);
        m_err = 1'b1;
        chk("t6_err_set", o_err, 1);
        wait_idle();
        push_exp(2, 1'b1);
        do_start(1, 2);
        chk("t6_err_clr", o_err, 0);
        wait_arm();
        for (int i = 0; i < 2; i++) pulse(3);
        wait_idle();
`endif

        repeat (5) tick();
        chk("queue_drained", q_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
